control_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 4-bit processor. It sits on the opposite side of the program counter interface. It drives `pc_enable`/`pc_load`/`pc_in`, captures the instruction byte addressed by the current PC, and emits one-cycle control strobes to the accumulator, ALU, flags, data memory and output register. Each instruction takes 3 cycles; memory loads take 4.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/instr_decoder.sv | 41 ++++
 rtl/control_sequencer.sv | 123 ++++++++++++
 tb/tb_control_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor: opcodes, sequencer states,
// ALU and accumulator-source codes, and the decoded control word.
package cpu_pkg;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdi = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpAnd = 4'h4;
  localparam logic [3:0] OpOr  = 4'h5;
  localparam logic [3:0] OpXor = 4'h6;
  localparam logic [3:0] OpLdm = 4'h7;
  localparam logic [3:0] OpSta = 4'h8;
  localparam logic [3:0] OpJmp = 4'h9;
  localparam logic [3:0] OpJz  = 4'hA;
  localparam logic [3:0] OpJc  = 4'hB;
  localparam logic [3:0] OpOut = 4'hC;
  localparam logic [3:0] OpHlt = 4'hF;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluXor = 3'd4;

  localparam logic [1:0] ASelImm = 2'd0;
  localparam logic [1:0] ASelAlu = 2'd1;
  localparam logic [1:0] ASelMem = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMemrd,
    StHalt
  } state_e;

  typedef struct packed {
    logic       a_load;
    logic [1:0] a_sel;
    logic [2:0] alu_op;
    logic       flag_load;
    logic       mem_we;
    logic       mem_rd;
    logic       out_load;
    logic       jmp;
    logic       jz;
    logic       jc;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CtrlNone = '0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode-to-control-word map; shared with the trace monitor.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = CtrlNone;
    case (opcode)
      OpLdi: begin
        ctrl.a_load = 1'b1;
        ctrl.a_sel  = ASelImm;
      end
      OpAdd, OpSub, OpAnd, OpOr, OpXor: begin
        ctrl.a_load    = 1'b1;
        ctrl.a_sel     = ASelAlu;
        ctrl.flag_load = 1'b1;
        case (opcode)
          OpSub:   ctrl.alu_op = AluSub;
          OpAnd:   ctrl.alu_op = AluAnd;
          OpOr:    ctrl.alu_op = AluOr;
          OpXor:   ctrl.alu_op = AluXor;
          default: ctrl.alu_op = AluAdd;
        endcase
      end
      OpLdm: ctrl.mem_rd   = 1'b1;
      OpSta: ctrl.mem_we   = 1'b1;
      OpJmp: ctrl.jmp      = 1'b1;
      OpJz:  ctrl.jz       = 1'b1;
      OpJc:  ctrl.jc       = 1'b1;
      OpOut: ctrl.out_load = 1'b1;
      OpHlt: ctrl.halt     = 1'b1;
      default: ctrl = CtrlNone;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: captures IR in FETCH, registers the decoded
// control word in DECODE, and emits one-cycle Moore strobes in EXEC/MEMRD.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [OPW+WIDTH-1:0] instr,
  input  logic                 zero_flag,
  input  logic                 carry_flag,
  input  logic [WIDTH-1:0]     mem_rdata,
  output logic                 pc_enable,
  output logic                 pc_load,
  output logic [WIDTH-1:0]     pc_in,
  output logic                 a_load,
  output logic [1:0]           a_sel,
  output logic [WIDTH-1:0]     imm,
  output logic [2:0]           alu_op,
  output logic                 flag_load,
  output logic [WIDTH-1:0]     mem_addr,
  output logic                 mem_we,
  output logic                 out_load,
  output logic                 halted
);

  state_e               state_q, state_d;
  logic [OPW+WIDTH-1:0] ir_q;
  ctrl_t                ctrl_q, ctrl_dec;
  logic [WIDTH-1:0]     operand;

  // Load data goes straight to the accumulator; the sequencer never inspects it.
  logic unused_mem_rdata;
  assign unused_mem_rdata = ^mem_rdata;

  assign operand = ir_q[WIDTH-1:0];

  instr_decoder #(
    .OPW (OPW)
  ) u_decoder (
    .opcode (ir_q[OPW+WIDTH-1 -: OPW]),
    .ctrl   (ctrl_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q   <= '0;
      ctrl_q <= CtrlNone;
    end else begin
      if (state_q == StFetch)  ir_q   <= instr;
      if (state_q == StDecode) ctrl_q <= ctrl_dec;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (run) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (ctrl_q.mem_rd)    state_d = StMemrd;
        else if (ctrl_q.halt) state_d = StHalt;
        else                  state_d = StFetch;
      end
      StMemrd:  state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are gated by reset so nothing strobes in a reset cycle.
  always_comb begin
    pc_enable = 1'b0;
    pc_load   = 1'b0;
    pc_in     = '0;
    a_load    = 1'b0;
    a_sel     = ASelImm;
    imm       = '0;
    alu_op    = AluAdd;
    flag_load = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    out_load  = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      imm = operand;
      case (state_q)
        StFetch: pc_enable = 1'b1;
        StExec: begin
          a_load    = ctrl_q.a_load;
          a_sel     = ctrl_q.a_sel;
          alu_op    = ctrl_q.alu_op;
          flag_load = ctrl_q.flag_load;
          mem_we    = ctrl_q.mem_we;
          out_load  = ctrl_q.out_load;
          if (ctrl_q.mem_we || ctrl_q.mem_rd) mem_addr = operand;
          if (ctrl_q.jmp || ctrl_q.jz || ctrl_q.jc) pc_in = operand;
          pc_load = ctrl_q.jmp | (ctrl_q.jz & zero_flag) | (ctrl_q.jc & carry_flag);
        end
        StMemrd: begin
          a_load   = 1'b1;
          a_sel    = ASelMem;
          mem_addr = operand;
        end
        StHalt:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction-level reference model
// with its own PC and program ROM, driven with directed and random programs.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, zero_flag, carry_flag;
  logic [7:0] instr;
  logic [3:0] mem_rdata;
  logic       pc_enable, pc_load, a_load, flag_load, mem_we, out_load, halted;
  logic [3:0] pc_in, imm, mem_addr;
  logic [1:0] a_sel;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  control_sequencer #(
    .WIDTH (4),
    .OPW   (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .instr      (instr),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .mem_rdata  (mem_rdata),
    .pc_enable  (pc_enable),
    .pc_load    (pc_load),
    .pc_in      (pc_in),
    .a_load     (a_load),
    .a_sel      (a_sel),
    .imm        (imm),
    .alu_op     (alu_op),
    .flag_load  (flag_load),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .out_load   (out_load),
    .halted     (halted)
  );

  typedef struct {
    bit       pc_enable, pc_load;
    bit [3:0] pc_in;
    bit       a_load;
    bit [1:0] a_sel;
    bit [3:0] imm;
    bit [2:0] alu_op;
    bit       flag_load;
    bit [3:0] mem_addr;
    bit       mem_we, out_load, halted;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;

  bit [7:0] rom [16];
  int       pc_m;
  bit [7:0] ir_m;
  bit       halted_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cmp_outputs(input string ph, input exp_t e);
    check_eq({ph, ".pc_enable"}, 32'(pc_enable), 32'(e.pc_enable));
    check_eq({ph, ".pc_load"},   32'(pc_load),   32'(e.pc_load));
    check_eq({ph, ".pc_in"},     32'(pc_in),     32'(e.pc_in));
    check_eq({ph, ".a_load"},    32'(a_load),    32'(e.a_load));
    check_eq({ph, ".a_sel"},     32'(a_sel),     32'(e.a_sel));
    check_eq({ph, ".imm"},       32'(imm),       32'(e.imm));
    check_eq({ph, ".alu_op"},    32'(alu_op),    32'(e.alu_op));
    check_eq({ph, ".flag_load"}, 32'(flag_load), 32'(e.flag_load));
    check_eq({ph, ".mem_addr"},  32'(mem_addr),  32'(e.mem_addr));
    check_eq({ph, ".mem_we"},    32'(mem_we),    32'(e.mem_we));
    check_eq({ph, ".out_load"},  32'(out_load),  32'(e.out_load));
    check_eq({ph, ".halted"},    32'(halted),    32'(e.halted));
  endtask

  // Inputs the sequencer must not react to combinationally get fresh noise.
  task automatic drive_noise(input int zf, input int cf);
    instr      = 8'($urandom);
    mem_rdata  = 4'($urandom);
    zero_flag  = (zf < 0) ? 1'($urandom) : zf[0];
    carry_flag = (cf < 0) ? 1'($urandom) : cf[0];
  endtask

  // Reset for two cycles, then idle with run low, then raise run.
  task automatic do_reset();
    exp_t e;
    e = '{default: 0};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1;
      run   = 1'($urandom);
      drive_noise(-1, -1);
      #1 cmp_outputs("reset", e);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b0;
      drive_noise(-1, -1);
      #1 cmp_outputs("idle", e);
    end
    @(negedge clk);
    run = 1'b1;
    drive_noise(-1, -1);
    #1 cmp_outputs("idle_run", e);
    pc_m     = 0;
    ir_m     = 8'h00;
    halted_m = 1'b0;
  endtask

  // One whole instruction; flags forced when zf/cf >= 0, random otherwise.
  task automatic exec_instr(input int zf, input int cf);
    exp_t     e;
    bit [3:0] op, opd;
    @(negedge clk);
    drive_noise(zf, cf);
    instr = rom[pc_m];
    e = '{default: 0};
    e.pc_enable = 1'b1;
    e.imm = ir_m[3:0];
    #1 cmp_outputs("fetch", e);
    ir_m = rom[pc_m];
    pc_m = (pc_m + 1) % 16;
    op   = ir_m[7:4];
    opd  = ir_m[3:0];

    @(negedge clk);
    drive_noise(zf, cf);
    e = '{default: 0};
    e.imm = opd;
    #1 cmp_outputs("decode", e);

    @(negedge clk);
    drive_noise(zf, cf);
    e = '{default: 0};
    e.imm = opd;
    if (op == 4'h1) begin
      e.a_load = 1'b1;
    end else if (op >= 4'h2 && op <= 4'h6) begin
      e.a_load    = 1'b1;
      e.a_sel     = 2'd1;
      e.flag_load = 1'b1;
      e.alu_op    = 3'(op - 4'h2);
    end else if (op == 4'h7) begin
      e.mem_addr = opd;
    end else if (op == 4'h8) begin
      e.mem_we   = 1'b1;
      e.mem_addr = opd;
    end else if (op == 4'h9) begin
      e.pc_load = 1'b1;
      e.pc_in   = opd;
    end else if (op == 4'hA) begin
      e.pc_load = zero_flag;
      e.pc_in   = opd;
    end else if (op == 4'hB) begin
      e.pc_load = carry_flag;
      e.pc_in   = opd;
    end else if (op == 4'hC) begin
      e.out_load = 1'b1;
    end
    #1 cmp_outputs("exec", e);
    if (e.pc_load) pc_m = int'(opd);

    if (op == 4'h7) begin
      @(negedge clk);
      drive_noise(zf, cf);
      mem_rdata = 4'd9;
      e = '{default: 0};
      e.imm      = opd;
      e.a_load   = 1'b1;
      e.a_sel    = 2'd2;
      e.mem_addr = opd;
      #1 cmp_outputs("memrd", e);
    end
    if (op == 4'hF) halted_m = 1'b1;
  endtask

  task automatic halt_cycles(input int n);
    exp_t e;
    e = '{default: 0};
    e.halted = 1'b1;
    e.imm    = ir_m[3:0];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      run = 1'b1;
      drive_noise(-1, -1);
      #1 cmp_outputs("halt", e);
    end
  endtask

  initial begin
    exp_t e;
    reset      = 1'b1;
    run        = 1'b0;
    instr      = 8'h00;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
    mem_rdata  = 4'h0;

    // Directed program: LDI/ADD/SUB, taken and untaken JZ, LDM, OUT, STA, JMP, HLT.
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0]  = 8'h15;
    rom[1]  = 8'h23;
    rom[2]  = 8'h31;
    rom[3]  = 8'hAA;
    rom[10] = 8'hAA;
    rom[11] = 8'h77;
    rom[12] = 8'hC0;
    rom[13] = 8'h82;
    rom[14] = 8'h9F;
    rom[15] = 8'hF0;
    do_reset();
    exec_instr(-1, -1);
    exec_instr(-1, -1);
    exec_instr(-1, -1);
    exec_instr(1, -1);
    exec_instr(0, -1);
    exec_instr(-1, -1);
    exec_instr(-1, -1);
    exec_instr(-1, -1);
    exec_instr(-1, -1);
    exec_instr(-1, -1);
    check_eq("model_halted", 32'(halted_m), 32'd1);
    halt_cycles(20);

    // Reset in the DECODE cycle of STA: no write may ever follow.
    for (int i = 0; i < 16; i++) rom[i] = 8'h82;
    do_reset();
    @(negedge clk);
    drive_noise(-1, -1);
    instr = 8'h82;
    e = '{default: 0};
    e.pc_enable = 1'b1;
    #1 cmp_outputs("sta_fetch", e);
    @(negedge clk);
    reset = 1'b1;
    drive_noise(-1, -1);
    e = '{default: 0};
    #1 cmp_outputs("sta_reset", e);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      reset = 1'b0;
      run   = 1'b0;
      drive_noise(-1, -1);
      #1 cmp_outputs("sta_after", e);
    end

    // Random programs, HLT made rare so most runs exercise many instructions.
    for (int round = 0; round < 8; round++) begin
      for (int i = 0; i < 16; i++) begin
        rom[i] = 8'($urandom);
        if (rom[i][7:4] == 4'hF && $urandom_range(0, 3) != 0) rom[i][7:4] = 4'h0;
      end
      do_reset();
      for (int n = 0; n < 40 && !halted_m; n++) exec_instr(-1, -1);
      if (halted_m) halt_cycles(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
